ps2_keymap_parser: RTL and testbench
====================================

PS2_KEYMAP_PARSER -- requirements
Module: ps2_keymap_parser

Interface
REQ-001 The parameter NUM_KEYS SHALL have default 16 and range 1..32; it is the number of tracked keys.
REQ-002 The parameter SYNC_STAGES SHALL have default 3 and range >=2; it is the depth of the ps2_state sampling shift register.
REQ-003 The parameter KEY_CODES SHALL be NUM_KEYS*9 bits; slot i is bits [9i+8:9i], with bit 8 = extended (E0) flag and bits 7:0 = scancode.
REQ-004 The default KEY_CODES SHALL be, slots 0..15: 1D, 1C, 1B, 23, 29, 5A, E0-75, E0-72, E0-6B, E0-74, 16, 1E, 26, 25, 2E, 36.
REQ-005 The parameter PREFIX_TIMEOUT SHALL have default 0, meaning disabled; otherwise it is the number of idle cycles after which a pending prefix is dropped.
REQ-006 clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-007 rst_n SHALL be an input, 1 bit wide: reset, asynchronous, active-low.
REQ-008 ps2_byte SHALL be an input, 8 bits wide: the received PS/2 byte, stable while ps2_state is high.
REQ-009 ps2_state SHALL be an input, 1 bit wide: byte-ready level from the PS/2 receiver; it may be held high any number of cycles.
REQ-010 keys SHALL be an output, NUM_KEYS bits wide: level 1 while key i is held.
REQ-011 key_press SHALL be an output, NUM_KEYS bits wide: one-cycle pulse on the 0->1 transition of keys[i].
REQ-012 key_release SHALL be an output, NUM_KEYS bits wide: one-cycle pulse on the 1->0 transition of keys[i].
REQ-013 ps2_posedge_state SHALL be an output, 1 bit wide: one-cycle byte-accept strobe.
REQ-014 ps2_state_sampling SHALL be an output, SYNC_STAGES bits wide: the sampling shift register, with bit 0 the newest sample.
REQ-015 err SHALL be an output, 1 bit wide: one-cycle pulse when a byte of 00 or FF is accepted.

Function
REQ-016 Each cycle, ps2_state_sampling SHALL shift left, with bit 0 <= ps2_state.
REQ-017 ps2_posedge_state SHALL be combinational and equal sampling[S-2] & ~sampling[S-1], so there is exactly one strobe per ps2_state rising edge, regardless of high duration.
REQ-018 On the rising edge where ps2_posedge_state=1, ps2_byte SHALL be accepted; the byte must be stable for at least SYNC_STAGES cycles after ps2_state rises.
REQ-019 Latency SHALL be as follows: ps2_state high before edge k causes the strobe during cycle k+S-2, and keys/key_press/key_release/err update at edge k+S-1.
REQ-020 The FSM SHALL have states IDLE, EXT, BRK and EXT_BRK, with transitions evaluated only on accepted bytes.
REQ-021 IDLE SHALL transition as follows: E0 -> EXT; F0 -> BRK; otherwise make(code, ext=0) -> IDLE.
REQ-022 EXT SHALL transition as follows: F0 -> EXT_BRK; E0 -> EXT; otherwise make(code, ext=1) -> IDLE.
REQ-023 BRK SHALL transition as follows: F0 -> BRK; E0 -> EXT, dropping the break; otherwise break(code, ext=0) -> IDLE.
REQ-024 EXT_BRK SHALL transition as follows: F0 -> EXT_BRK; E0 -> EXT; otherwise break(code, ext=1) -> IDLE.
REQ-025 A byte of 00 or FF in any state SHALL pulse err, force the FSM to IDLE, and leave keys unchanged.
REQ-026 make(c,e) SHALL set keys[i] for every slot i with KEY_CODES slot == {e,c}; break(c,e) SHALL clear those slots; a code matching no slot is ignored.
REQ-027 Duplicate table entries SHALL all update together.
REQ-028 A typematic repeat (make while keys[i]=1) SHALL leave keys[i] at 1 and produce no key_press.
REQ-029 A break while keys[i]=0 SHALL produce no key_release.
REQ-030 key_press and key_release SHALL be registered and high for exactly one cycle, and never simultaneously for the same i.
REQ-031 If PREFIX_TIMEOUT>0, the FSM SHALL return to IDLE from EXT, BRK or EXT_BRK after PREFIX_TIMEOUT consecutive cycles with no strobe; the counter restarts on each strobe and saturates.
REQ-032 A strobe in the same cycle as a timeout expiry SHALL take priority, and the byte is processed in the current prefix state.

Reset
REQ-033 While rst_n=0, keys, key_press, key_release, err and ps2_state_sampling SHALL be 0, the FSM SHALL be IDLE, and the timeout counter SHALL be 0, all asynchronously.
REQ-034 Reset asserted mid-sequence (after E0 or F0) SHALL discard the prefix, so that a byte following release is decoded from IDLE.
REQ-035 No strobe SHALL occur in the cycle after reset release, even if ps2_state is already high, because sampling starts at 0.

Verification
REQ-036 The bench SHALL check that ps2_byte=1D with ps2_state held high for 13 cycles gives exactly one ps2_posedge_state pulse, keys[0]=1 at edge k+2, and key_press=0x0001 for one cycle.
REQ-037 The bench SHALL check that the sequence 1D, F0, 1D gives keys[0] 0->1->0, key_release[0] pulsed once, and no key_release from the F0 byte.
REQ-038 The bench SHALL check that the sequence E0, 75 then E0, F0, 75 gives keys[6] set then cleared, and that a plain 75 alone leaves keys unchanged.
REQ-039 The bench SHALL check that 1D sent three times (typematic) gives one key_press pulse, keys[0] staying 1, and no release.
REQ-040 The bench SHALL check that F0, FF, 1D gives an err pulse on FF, that 1D is treated as a make, and keys[0]=1.
REQ-041 The bench SHALL check that, with PREFIX_TIMEOUT=8, an F0 followed by 1D after 9 idle cycles is decoded as a make (keys[0]=1); and that rst_n pulsed low after E0, then 75, leaves keys=0.

Source files
------------

// File: rtl/ps2_keymap_parser.sv
// PS/2 scancode-set-2 key map parser.
// Detects a rising edge of the receiver's byte-ready level through a sampling
// shift register. Each accepted byte is decoded through the E0/F0 prefix
// FSM, and a level bit is kept per tracked key, with registered press and
// release pulses.
// Ports:
//   clk, rst_n         - clock and asynchronous active-low reset
//   ps2_byte           - received byte, stable while ps2_state is high
//   ps2_state          - byte-ready level from the PS/2 receiver
//   keys               - held state per key slot
//   key_press          - one-cycle pulse on the 0->1 edge of a keys bit
//   key_release        - one-cycle pulse on the 1->0 edge of a keys bit
//   ps2_posedge_state  - one-cycle byte-accept strobe
//   ps2_state_sampling - sampling shift register (bit 0 is the newest sample)
//   err                - one-cycle pulse when a 00/FF byte is accepted
module ps2_keymap_parser #(
    parameter int                    NUM_KEYS       = 16,
    parameter int                    SYNC_STAGES    = 3,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {
        9'h036, 9'h02E, 9'h025, 9'h026, 9'h01E, 9'h016, 9'h174, 9'h16B,
        9'h172, 9'h175, 9'h05A, 9'h029, 9'h023, 9'h01B, 9'h01C, 9'h01D},
    parameter int                    PREFIX_TIMEOUT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             ps2_byte,
    input  logic                   ps2_state,
    output logic [NUM_KEYS-1:0]    keys,
    output logic [NUM_KEYS-1:0]    key_press,
    output logic [NUM_KEYS-1:0]    key_release,
    output logic                   ps2_posedge_state,
    output logic [SYNC_STAGES-1:0] ps2_state_sampling,
    output logic                   err
);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    localparam int TW = (PREFIX_TIMEOUT > 0) ? $clog2(PREFIX_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_MAX  = TW'(PREFIX_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = (PREFIX_TIMEOUT > 0) ? TW'(PREFIX_TIMEOUT - 1) : '0;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sampling_q, sampling_d;
    logic [NUM_KEYS-1:0]    keys_q, keys_d;
    logic [NUM_KEYS-1:0]    press_q, press_d;
    logic [NUM_KEYS-1:0]    release_q, release_d;
    logic                   err_q, err_d;
    logic [TW-1:0]          tmo_q, tmo_d;

    logic                   strobe;
    logic                   do_make;
    logic                   do_break;
    logic                   code_ext;
    logic [NUM_KEYS-1:0]    match;

    always_comb begin
        sampling_d = {sampling_q[SYNC_STAGES-2:0], ps2_state};
        strobe     = sampling_q[SYNC_STAGES-2] & ~sampling_q[SYNC_STAGES-1];
        state_d    = state_q;
        err_d      = 1'b0;
        tmo_d      = tmo_q;
        do_make    = 1'b0;
        do_break   = 1'b0;
        code_ext   = 1'b0;

        // Idle-cycle counter. An expiry only drops a pending prefix. A strobe
        // in the same cycle overrides the expiry, because the byte decode
        // below runs from state_q and assigns state_d after this.
        if (PREFIX_TIMEOUT > 0) begin
            if (strobe) begin
                tmo_d = '0;
            end else begin
                if (tmo_q != TMO_MAX) tmo_d = tmo_q + TW'(1);
                if (tmo_q >= TMO_LAST && state_q != IDLE) state_d = IDLE;
            end
        end

        if (strobe) begin
            if (ps2_byte == 8'h00 || ps2_byte == 8'hFF) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (ps2_byte == 8'hE0)      state_d = EXT;
                        else if (ps2_byte == 8'hF0) state_d = BRK;
                        else begin
                            do_make = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    EXT: begin
                        if (ps2_byte == 8'hF0)      state_d = EXT_BRK;
                        else if (ps2_byte == 8'hE0) state_d = EXT;
                        else begin
                            do_make  = 1'b1;
                            code_ext = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                    BRK: begin
                        if (ps2_byte == 8'hF0)      state_d = BRK;
                        else if (ps2_byte == 8'hE0) state_d = EXT;
                        else begin
                            do_break = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                    EXT_BRK: begin
                        if (ps2_byte == 8'hF0)      state_d = EXT_BRK;
                        else if (ps2_byte == 8'hE0) state_d = EXT;
                        else begin
                            do_break = 1'b1;
                            code_ext = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        // Every matching slot updates, so duplicate table entries move together.
        match = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            match[i] = (KEY_CODES[9*i +: 9] == {code_ext, ps2_byte});
        end

        keys_d = keys_q;
        if (do_make)       keys_d = keys_q | match;
        else if (do_break) keys_d = keys_q & ~match;

        // Pulses come from the level change, so repeats and stray breaks produce none.
        press_d   = keys_d & ~keys_q;
        release_d = keys_q & ~keys_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sampling_q <= '0;
            keys_q     <= '0;
            press_q    <= '0;
            release_q  <= '0;
            err_q      <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            sampling_q <= sampling_d;
            keys_q     <= keys_d;
            press_q    <= press_d;
            release_q  <= release_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
        end
    end

    assign keys               = keys_q;
    assign key_press          = press_q;
    assign key_release        = release_q;
    assign err                = err_q;
    assign ps2_state_sampling = sampling_q;
    assign ps2_posedge_state  = strobe;

endmodule

// File: tb/tb_ps2_keymap_parser.sv
// Testbench for ps2_keymap_parser: default instance plus PREFIX_TIMEOUT=8 instance.
// Expected press/release/err events are queued as bytes are sent and matched
// against the default instance's pulses as they appear.
module tb_ps2_keymap_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ps2_byte = 8'h00;
    logic        ps2_state = 1'b0;

    logic [15:0] keys, key_press, key_release;
    logic        ps2_posedge_state, err;
    logic [2:0]  sampling;

    logic [15:0] t_keys, t_press, t_release;
    logic        t_strobe, t_err;
    logic [2:0]  t_sampling;

    typedef struct packed {
        logic [15:0] press;
        logic [15:0] rel;
        logic        err;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail = 0;
    int  strobe_cnt = 0;
    int  c0;

    always #5 clk = ~clk;

    ps2_keymap_parser u_dut (
        .clk(clk), .rst_n(rst_n), .ps2_byte(ps2_byte), .ps2_state(ps2_state),
        .keys(keys), .key_press(key_press), .key_release(key_release),
        .ps2_posedge_state(ps2_posedge_state), .ps2_state_sampling(sampling),
        .err(err)
    );

    ps2_keymap_parser #(.PREFIX_TIMEOUT(8)) u_tmo (
        .clk(clk), .rst_n(rst_n), .ps2_byte(ps2_byte), .ps2_state(ps2_state),
        .keys(t_keys), .key_press(t_press), .key_release(t_release),
        .ps2_posedge_state(t_strobe), .ps2_state_sampling(t_sampling),
        .err(t_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every pulse group on the default instance must match the queue head.
    always @(negedge clk) begin
        ev_t obs_ev;
        ev_t exp_ev;
        if (rst_n) begin
            if (ps2_posedge_state) strobe_cnt++;
            if ((|key_press) || (|key_release) || err) begin
                obs_ev = '{press: key_press, rel: key_release, err: err};
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 64'(obs_ev), 64'(0));
                end else begin
                    exp_ev = exp_q.pop_front();
                    check("event", 64'(obs_ev), 64'(exp_ev));
                end
            end
        end
    end

    task automatic expect_ev(input logic [15:0] p, input logic [15:0] r, input logic e);
        exp_q.push_back('{press: p, rel: r, err: e});
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        ps2_byte  = b;
        ps2_state = 1'b1;
        repeat (4) @(negedge clk);
        ps2_state = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'(0));
        @(negedge clk);
        rst_n     = 1'b0;
        ps2_state = 1'b0;
        @(negedge clk);
        check({tag, "_rst_outputs"}, {keys, key_press, key_release, err, sampling}, 64'(0));
        check({tag, "_rst_tmo_keys"}, 64'(t_keys), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset("t0");

        // Single make with a long high level: one strobe, fixed latency
        @(negedge clk);
        ps2_byte  = 8'h1D;
        ps2_state = 1'b1;
        c0 = strobe_cnt;
        expect_ev(16'h0001, 16'h0000, 1'b0);
        @(negedge clk);
        check("t1_no_strobe_edge_k", 64'(ps2_posedge_state), 64'(0));
        @(negedge clk);
        check("t1_strobe", 64'(ps2_posedge_state), 64'(1));
        check("t1_keys_before", 64'(keys), 64'(0));
        @(negedge clk);
        check("t1_keys_at_k2", 64'(keys), 64'h0001);
        check("t1_press", 64'(key_press), 64'h0001);
        @(negedge clk);
        check("t1_press_one_cycle", 64'(key_press), 64'(0));
        repeat (9) @(negedge clk);
        ps2_state = 1'b0;
        repeat (5) @(negedge clk);
        check("t1_one_strobe", 64'(strobe_cnt - c0), 64'(1));

        // Make, break
        do_reset("t2");
        expect_ev(16'h0001, 16'h0000, 1'b0);
        send(8'h1D);
        check("t2_keys_made", 64'(keys), 64'h0001);
        send(8'hF0);
        check("t2_keys_after_f0", 64'(keys), 64'h0001);
        expect_ev(16'h0000, 16'h0001, 1'b0);
        send(8'h1D);
        check("t2_keys_broken", 64'(keys), 64'(0));

        // Extended make/break, and plain code with no matching slot
        do_reset("t3");
        expect_ev(16'h0040, 16'h0000, 1'b0);
        send(8'hE0);
        send(8'h75);
        check("t3_ext_make", 64'(keys), 64'h0040);
        expect_ev(16'h0000, 16'h0040, 1'b0);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check("t3_ext_break", 64'(keys), 64'(0));
        send(8'h75);
        check("t3_plain_75", 64'(keys), 64'(0));

        // Typematic repeat
        do_reset("t4");
        expect_ev(16'h0001, 16'h0000, 1'b0);
        send(8'h1D);
        send(8'h1D);
        send(8'h1D);
        check("t4_typematic_keys", 64'(keys), 64'h0001);

        // Error byte cancels the break prefix
        do_reset("t5");
        send(8'hF0);
        expect_ev(16'h0000, 16'h0000, 1'b1);
        send(8'hFF);
        expect_ev(16'h0001, 16'h0000, 1'b0);
        send(8'h1D);
        check("t5_make_after_err", 64'(keys), 64'h0001);

        // Prefix timeout: the timeout instance forgets F0, the default one keeps it
        do_reset("t6");
        send(8'hF0);
        repeat (20) @(negedge clk);
        send(8'h1D);
        check("t6_tmo_make", 64'(t_keys), 64'h0001);
        check("t6_default_break", 64'(keys), 64'(0));

        // Reset mid-prefix discards E0
        do_reset("t7");
        send(8'hE0);
        do_reset("t7b");
        send(8'h75);
        check("t7_keys_default", 64'(keys), 64'(0));
        check("t7_keys_tmo", 64'(t_keys), 64'(0));

        repeat (5) @(negedge clk);
        check("final_queue_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
